// File: rtl/digit_pipe_pkg.sv
// ============================================================================
// Package  : digit_pipe_pkg
// Brief    : Shared widths and controller state encoding for digit_pipe_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package digit_pipe_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;
    localparam int TO_W   = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/digit_pipe_wdog.sv
// ============================================================================
// Module   : digit_pipe_wdog
// Brief    : Idle-cycle watchdog; a limit of zero disables it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module digit_pipe_wdog #(
    parameter int TO_W = digit_pipe_pkg::TO_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            en,
    input  logic            kick,
    input  logic [TO_W-1:0] limit,
    output logic            expired
);

    logic [TO_W-1:0] r_cnt;
    logic [TO_W-1:0] w_cnt_inc;
    logic            w_active;

    assign w_active  = en && (limit != '0);
    assign w_cnt_inc = r_cnt + TO_W'(1);

    // Flags on the edge where the count reaches the limit, so the owner
    // can change state on that same edge.
    assign expired = w_active && !kick && (w_cnt_inc == limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || (en && kick)) begin
            r_cnt <= '0;
        end else if (w_active && (r_cnt != limit)) begin
            r_cnt <= w_cnt_inc;
        end
    end

endmodule

`default_nettype wire

// File: rtl/digit_pipe_ctrl.sv
// ============================================================================
// Module   : digit_pipe_ctrl
// Brief    : Job controller that starts the page chain and gates its streams.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module digit_pipe_ctrl #(
    parameter int DATA_W = digit_pipe_pkg::DATA_W,
    parameter int CNT_W  = digit_pipe_pkg::CNT_W,
    parameter int TO_W   = digit_pipe_pkg::TO_W
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CNT_W-1:0]  cfg_in_words,
    input  logic [CNT_W-1:0]  cfg_out_words,
    input  logic [TO_W-1:0]   cfg_timeout,
    input  logic [DATA_W-1:0] s_TDATA,
    input  logic              s_TVALID,
    output logic              s_TREADY,
    output logic [DATA_W-1:0] pipe_in_TDATA,
    output logic              pipe_in_TVALID,
    input  logic              pipe_in_TREADY,
    input  logic [DATA_W-1:0] pipe_out_TDATA,
    input  logic              pipe_out_TVALID,
    output logic              pipe_out_TREADY,
    output logic [DATA_W-1:0] m_TDATA,
    output logic              m_TVALID,
    input  logic              m_TREADY,
    output logic              pipe_ap_start,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic [CNT_W-1:0]  in_cnt,
    output logic [CNT_W-1:0]  out_cnt
);

    import digit_pipe_pkg::*;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_in_words;
    logic [CNT_W-1:0]  r_out_words;
    logic [TO_W-1:0]   r_timeout;
    logic [CNT_W-1:0]  r_in_cnt;
    logic [CNT_W-1:0]  r_out_cnt;
    logic [CNT_W-1:0]  w_in_cnt_nxt;
    logic [CNT_W-1:0]  w_out_cnt_nxt;
    logic              w_accept;
    logic              w_in_open;
    logic              w_out_open;
    logic              w_s_hs;
    logic              w_m_hs;
    logic              w_complete;
    logic              w_expired;

    assign pipe_in_TDATA = s_TDATA;
    assign m_TDATA       = pipe_out_TDATA;
    assign in_cnt        = r_in_cnt;
    assign out_cnt       = r_out_cnt;

    assign w_accept   = cfg_valid && (r_state == ST_IDLE);
    assign w_in_open  = (r_in_cnt < r_in_words);
    assign w_out_open = (r_out_cnt < r_out_words);
    assign w_s_hs     = s_TVALID && s_TREADY;
    assign w_m_hs     = m_TVALID && m_TREADY;

    assign w_in_cnt_nxt  = (w_s_hs && w_in_open)  ? r_in_cnt + CNT_W'(1)  : r_in_cnt;
    assign w_out_cnt_nxt = (w_m_hs && w_out_open) ? r_out_cnt + CNT_W'(1) : r_out_cnt;

    // Completion looks at post-handshake counts so the final word and the
    // move to DONE share one edge; an empty job completes on its first cycle.
    assign w_complete = (w_in_cnt_nxt == r_in_words) && (w_out_cnt_nxt == r_out_words);

    digit_pipe_wdog #(
        .TO_W (TO_W)
    ) u_wdog (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .clr     (w_accept),
        .en      (r_state == ST_RUN),
        .kick    (w_s_hs || w_m_hs),
        .limit   (r_timeout),
        .expired (w_expired)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (cfg_valid)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_complete) w_state_nxt = ST_DONE;
                     else if (w_expired) w_state_nxt = ST_ERR;
            ST_DONE: w_state_nxt = ST_IDLE;
            ST_ERR:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready       = 1'b0;
        pipe_ap_start   = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        err_timeout     = 1'b0;
        pipe_in_TVALID  = 1'b0;
        s_TREADY        = 1'b0;
        m_TVALID        = 1'b0;
        pipe_out_TREADY = 1'b0;
        case (r_state)
            ST_IDLE: cfg_ready = 1'b1;
            ST_RUN: begin
                pipe_ap_start   = 1'b1;
                busy            = 1'b1;
                pipe_in_TVALID  = s_TVALID && w_in_open;
                s_TREADY        = pipe_in_TREADY && w_in_open;
                m_TVALID        = pipe_out_TVALID && w_out_open;
                pipe_out_TREADY = m_TREADY && w_out_open;
            end
            ST_DONE: done        = 1'b1;
            ST_ERR:  err_timeout = 1'b1;
            default: ;
        endcase
    end

    // Counters keep their final values after DONE/ERR until the next accept.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_in_words  <= '0;
            r_out_words <= '0;
            r_timeout   <= '0;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
        end else if (w_accept) begin
            r_in_words  <= cfg_in_words;
            r_out_words <= cfg_out_words;
            r_timeout   <= cfg_timeout;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
        end else begin
            r_in_cnt    <= w_in_cnt_nxt;
            r_out_cnt   <= w_out_cnt_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_digit_pipe_ctrl.sv
// ============================================================================
// Module   : tb_digit_pipe_ctrl
// Brief    : Randomised job-level bench for digit_pipe_ctrl with a word-count model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_digit_pipe_ctrl;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;
    localparam int TO_W   = 24;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n;
    logic              cfg_valid, cfg_ready;
    logic [CNT_W-1:0]  cfg_in_words, cfg_out_words;
    logic [TO_W-1:0]   cfg_timeout;
    logic [DATA_W-1:0] s_TDATA, pipe_in_TDATA, pipe_out_TDATA, m_TDATA;
    logic              s_TVALID, s_TREADY, pipe_in_TVALID, pipe_in_TREADY;
    logic              pipe_out_TVALID, pipe_out_TREADY, m_TVALID, m_TREADY;
    logic              pipe_ap_start, busy, done, err_timeout;
    logic [CNT_W-1:0]  in_cnt, out_cnt;

    always #5 ap_clk = ~ap_clk;

    digit_pipe_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .TO_W(TO_W)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_in_words(cfg_in_words), .cfg_out_words(cfg_out_words), .cfg_timeout(cfg_timeout),
        .s_TDATA(s_TDATA), .s_TVALID(s_TVALID), .s_TREADY(s_TREADY),
        .pipe_in_TDATA(pipe_in_TDATA), .pipe_in_TVALID(pipe_in_TVALID), .pipe_in_TREADY(pipe_in_TREADY),
        .pipe_out_TDATA(pipe_out_TDATA), .pipe_out_TVALID(pipe_out_TVALID), .pipe_out_TREADY(pipe_out_TREADY),
        .m_TDATA(m_TDATA), .m_TVALID(m_TVALID), .m_TREADY(m_TREADY),
        .pipe_ap_start(pipe_ap_start), .busy(busy), .done(done), .err_timeout(err_timeout),
        .in_cnt(in_cnt), .out_cnt(out_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Observations gathered by run_job
    int o_s_hs, o_pout_hs, o_m_hs, o_done_n, o_err_n, o_done_at, o_err_at;
    int o_last_hs, o_start_n, o_data_bad, o_leak, o_late_s, o_late_p;
    logic o_cfg_rdy, o_idle_rdy;
    logic [DATA_W-1:0] src_w[$];
    logic [DATA_W-1:0] res_w[$];

    // Model expectations
    int e_s, e_m, e_end, e_run;
    bit e_done, e_err;

    task automatic zero_inputs();
        cfg_valid = 1'b0; s_TVALID = 1'b0; pipe_in_TREADY = 1'b0;
        pipe_out_TVALID = 1'b0; m_TREADY = 1'b0; s_TDATA = '0; pipe_out_TDATA = '0;
    endtask

    // Drives one job: a source offering src_n words, a pipeline that offers
    // pipe_n results once it has absorbed thresh inputs, and a sink.
    // Iteration k is the clock period following edge k-1; accept is edge 0.
    task automatic run_job(input int iw, input int ow, input int to, input int src_n,
                           input int pipe_n, input int thresh, input bit rs, input bit rp,
                           input bit rm, input int budget);
        int prx, end_at;
        bit hs_s, hs_pi, hs_po, hs_m;
        src_w.delete(); res_w.delete();
        for (int i = 0; i < src_n; i++) src_w.push_back($urandom);
        for (int i = 0; i < pipe_n; i++) res_w.push_back($urandom);
        o_s_hs = 0; o_pout_hs = 0; o_m_hs = 0; o_done_n = 0; o_err_n = 0;
        o_done_at = -1; o_err_at = -1; o_last_hs = 0; o_start_n = 0;
        o_data_bad = 0; o_leak = 0; o_late_s = 0; o_late_p = 0; o_idle_rdy = 1'b0;
        prx = 0; end_at = -1;
        cfg_in_words = CNT_W'(iw); cfg_out_words = CNT_W'(ow); cfg_timeout = TO_W'(to);
        cfg_valid = 1'b1;
        @(negedge ap_clk);
        o_cfg_rdy = cfg_ready;
        @(posedge ap_clk); #1;
        cfg_valid = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            s_TVALID        = (o_s_hs < src_n) && (!rs || ($urandom_range(0, 3) != 0));
            s_TDATA         = (o_s_hs < src_n) ? src_w[o_s_hs] : '0;
            pipe_in_TREADY  = !rp || ($urandom_range(0, 1) == 1);
            pipe_out_TVALID = (o_pout_hs < pipe_n) && (prx >= thresh);
            pipe_out_TDATA  = (o_pout_hs < pipe_n) ? res_w[o_pout_hs] : '0;
            m_TREADY        = !rm || ($urandom_range(0, 1) == 1);
            @(negedge ap_clk);
            hs_s  = s_TVALID && s_TREADY;
            hs_pi = pipe_in_TVALID && pipe_in_TREADY;
            hs_po = pipe_out_TVALID && pipe_out_TREADY;
            hs_m  = m_TVALID && m_TREADY;
            if (hs_s != hs_pi || hs_po != hs_m) o_data_bad++;
            if (hs_pi && (o_s_hs >= src_n || pipe_in_TDATA !== src_w[o_s_hs])) o_data_bad++;
            if (hs_m && (o_m_hs >= pipe_n || m_TDATA !== res_w[o_m_hs])) o_data_bad++;
            if (o_s_hs >= iw && s_TREADY) o_late_s++;
            if (o_m_hs >= ow && pipe_out_TREADY) o_late_p++;
            if (pipe_ap_start) o_start_n++;
            if (end_at >= 0 && k == end_at + 1) o_idle_rdy = cfg_ready;
            if (done) begin o_done_n++; if (o_done_at < 0) o_done_at = k; end
            if (err_timeout) begin o_err_n++; if (o_err_at < 0) o_err_at = k; end
            if (end_at < 0 && (done || err_timeout)) end_at = k;
            if (end_at >= 0 && (s_TREADY || pipe_in_TVALID || m_TVALID || pipe_out_TREADY || pipe_ap_start))
                o_leak++;
            @(posedge ap_clk);
            if (hs_s)  begin o_s_hs++; o_last_hs = k; end
            if (hs_pi) prx++;
            if (hs_po) o_pout_hs++;
            if (hs_m)  begin o_m_hs++; o_last_hs = k; end
            #1;
            if (end_at >= 0 && k >= end_at + 1) break;
        end
        zero_inputs();
    endtask

    // Job-level reference: counts are limits clipped by what is offered;
    // completion follows the final handshake by one cycle, expiry follows
    // the last handshake (or the accept) by limit+1 cycles.
    task automatic model_job(input int iw, input int ow, input int to, input int src_n,
                             input int pipe_n, input int thresh, input int budget);
        e_s    = (src_n < iw) ? src_n : iw;
        e_m    = (e_s >= thresh) ? ((pipe_n < ow) ? pipe_n : ow) : 0;
        e_done = (e_s == iw) && (e_m == ow);
        e_err  = !e_done && (to != 0);
        if (e_done)     e_end = (iw == 0 && ow == 0) ? 2 : o_last_hs + 1;
        else if (e_err) e_end = o_last_hs + to + 1;
        else            e_end = -1;
        e_run = (e_end < 0) ? budget : e_end - 1;
    endtask

    task automatic test_reset();
        zero_inputs();
        ap_rst_n = 1'b0;
        s_TVALID = 1'b1; pipe_in_TREADY = 1'b1; pipe_out_TVALID = 1'b1; m_TREADY = 1'b1;
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        checks++;
        if ({cfg_ready, pipe_ap_start, busy, done, err_timeout} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 10000", {cfg_ready, pipe_ap_start, busy, done, err_timeout});
        end
        checks++;
        if ({s_TREADY, pipe_in_TVALID, m_TVALID, pipe_out_TREADY} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_streams: got %b want 0000", {s_TREADY, pipe_in_TVALID, m_TVALID, pipe_out_TREADY});
        end
        checks++;
        if (in_cnt !== '0 || out_cnt !== '0) begin
            errors++;
            $display("FAIL reset_counts: got %0d/%0d want 0/0", in_cnt, out_cnt);
        end
        zero_inputs();
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
    endtask

    task automatic test_basic();
        run_job(8, 1, 0, 8, 1, 8, 1'b1, 1'b0, 1'b0, 200);
        model_job(8, 1, 0, 8, 1, 8, 200);
        checks++; if (o_cfg_rdy !== 1'b1) begin errors++; $display("FAIL basic cfg_ready: got %b want 1", o_cfg_rdy); end
        checks++; if (o_s_hs != e_s) begin errors++; $display("FAIL basic s_hs: got %0d want %0d", o_s_hs, e_s); end
        checks++; if (o_m_hs != e_m) begin errors++; $display("FAIL basic m_hs: got %0d want %0d", o_m_hs, e_m); end
        checks++; if (o_done_n != 1 || o_done_at != e_end) begin
            errors++; $display("FAIL basic done: got %0d pulses at %0d want 1 at %0d", o_done_n, o_done_at, e_end);
        end
        checks++; if (o_start_n != e_run) begin errors++; $display("FAIL basic ap_start cycles: got %0d want %0d", o_start_n, e_run); end
        checks++; if (in_cnt !== CNT_W'(e_s) || out_cnt !== CNT_W'(e_m)) begin
            errors++; $display("FAIL basic counts: got %0d/%0d want %0d/%0d", in_cnt, out_cnt, e_s, e_m);
        end
        checks++; if (o_data_bad != 0 || o_leak != 0) begin
            errors++; $display("FAIL basic data/leak: got %0d/%0d want 0/0", o_data_bad, o_leak);
        end
        checks++; if (o_idle_rdy !== 1'b1) begin errors++; $display("FAIL basic idle_ready: got %b want 1", o_idle_rdy); end
    endtask

    task automatic test_src_overflow();
        run_job(8, 1, 0, 12, 1, 8, 1'b0, 1'b1, 1'b0, 200);
        model_job(8, 1, 0, 12, 1, 8, 200);
        checks++; if (o_s_hs != e_s) begin errors++; $display("FAIL overflow s_hs: got %0d want %0d", o_s_hs, e_s); end
        checks++; if (o_late_s != 0) begin errors++; $display("FAIL overflow late s_TREADY: got %0d want 0", o_late_s); end
        checks++; if (o_done_n != 1 || o_done_at != e_end) begin
            errors++; $display("FAIL overflow done: got %0d pulses at %0d want 1 at %0d", o_done_n, o_done_at, e_end);
        end
    endtask

    task automatic test_surplus();
        run_job(2, 4, 0, 2, 6, 2, 1'b0, 1'b0, 1'b1, 300);
        model_job(2, 4, 0, 2, 6, 2, 300);
        checks++; if (o_m_hs != e_m || o_pout_hs != e_m) begin
            errors++; $display("FAIL surplus fwd: got m=%0d pipe=%0d want %0d", o_m_hs, o_pout_hs, e_m);
        end
        checks++; if (o_late_p != 0) begin errors++; $display("FAIL surplus late pipe_out_TREADY: got %0d want 0", o_late_p); end
        checks++; if (o_done_n != 1 || o_done_at != e_end) begin
            errors++; $display("FAIL surplus done: got %0d pulses at %0d want 1 at %0d", o_done_n, o_done_at, e_end);
        end
        checks++; if (o_data_bad != 0) begin errors++; $display("FAIL surplus data: got %0d want 0", o_data_bad); end
    endtask

    task automatic test_zero_job();
        run_job(0, 0, 5, 3, 3, 0, 1'b0, 1'b0, 1'b0, 20);
        model_job(0, 0, 5, 3, 3, 0, 20);
        checks++; if (o_s_hs != 0 || o_m_hs != 0) begin
            errors++; $display("FAIL zero hs: got %0d/%0d want 0/0", o_s_hs, o_m_hs);
        end
        checks++; if (o_done_n != 1 || o_done_at != e_end || o_err_n != 0) begin
            errors++; $display("FAIL zero done: got %0d at %0d err %0d want 1 at %0d err 0", o_done_n, o_done_at, o_err_n, e_end);
        end
        checks++; if (o_start_n != e_run) begin errors++; $display("FAIL zero ap_start cycles: got %0d want %0d", o_start_n, e_run); end
    endtask

    task automatic test_watchdog();
        run_job(8, 1, 20, 8, 0, 8, 1'b1, 1'b0, 1'b0, 200);
        model_job(8, 1, 20, 8, 0, 8, 200);
        checks++; if (o_err_n != 1 || o_err_at != e_end) begin
            errors++; $display("FAIL wdog err: got %0d pulses at %0d want 1 at %0d", o_err_n, o_err_at, e_end);
        end
        checks++; if (o_done_n != 0) begin errors++; $display("FAIL wdog done: got %0d want 0", o_done_n); end
        checks++; if (in_cnt !== CNT_W'(e_s) || out_cnt !== CNT_W'(e_m)) begin
            errors++; $display("FAIL wdog held counts: got %0d/%0d want %0d/%0d", in_cnt, out_cnt, e_s, e_m);
        end
        checks++; if (o_idle_rdy !== 1'b1 || o_leak != 0) begin
            errors++; $display("FAIL wdog idle: got ready=%b leak=%0d want 1/0", o_idle_rdy, o_leak);
        end
    endtask

    task automatic test_reset_mid_job();
        run_job(8, 1, 0, 3, 1, 8, 1'b0, 1'b0, 1'b0, 100);
        model_job(8, 1, 0, 3, 1, 8, 100);
        checks++; if (o_done_n != 0 || o_err_n != 0 || o_start_n != e_run) begin
            errors++; $display("FAIL nowdog: got done=%0d err=%0d start=%0d want 0/0/%0d", o_done_n, o_err_n, o_start_n, e_run);
        end
        checks++; if (in_cnt !== CNT_W'(e_s)) begin errors++; $display("FAIL midjob in_cnt: got %0d want %0d", in_cnt, e_s); end
        @(negedge ap_clk);
        s_TVALID = 1'b1; pipe_in_TREADY = 1'b1; pipe_out_TVALID = 1'b1; m_TREADY = 1'b1;
        #1;
        checks++; if (s_TREADY !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL midjob pre-reset: got s_TREADY=%b busy=%b want 1/1", s_TREADY, busy);
        end
        ap_rst_n = 1'b0;
        #1;
        checks++;
        if ({cfg_ready, pipe_ap_start, busy, s_TREADY, pipe_in_TVALID, m_TVALID, pipe_out_TREADY} !== 7'b1000000) begin
            errors++;
            $display("FAIL midjob async reset: got %b want 1000000",
                     {cfg_ready, pipe_ap_start, busy, s_TREADY, pipe_in_TVALID, m_TVALID, pipe_out_TREADY});
        end
        checks++; if (in_cnt !== '0) begin errors++; $display("FAIL midjob cleared in_cnt: got %0d want 0", in_cnt); end
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        zero_inputs();
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 5; j++) begin
            int iw, ow, src_n, pipe_n, thr;
            iw     = (j == 0) ? 2 : $urandom_range(1, 10);
            ow     = (j == 0) ? 1 : $urandom_range(1, 4);
            src_n  = iw + ((j == 0) ? 0 : $urandom_range(0, 3));
            pipe_n = ow + ((j == 0) ? 0 : $urandom_range(0, 2));
            thr    = (j == 0) ? iw : $urandom_range(0, iw);
            run_job(iw, ow, 0, src_n, pipe_n, thr, j != 0, j != 0, j != 0, 400);
            model_job(iw, ow, 0, src_n, pipe_n, thr, 400);
            checks++; if (o_cfg_rdy !== 1'b1 || o_s_hs != e_s || o_m_hs != e_m) begin
                errors++; $display("FAIL job%0d counts: got rdy=%b s=%0d m=%0d want 1/%0d/%0d", j, o_cfg_rdy, o_s_hs, o_m_hs, e_s, e_m);
            end
            checks++; if (o_done_n != 1 || o_done_at != e_end || o_data_bad != 0) begin
                errors++; $display("FAIL job%0d done: got %0d at %0d bad=%0d want 1 at %0d bad=0", j, o_done_n, o_done_at, o_data_bad, e_end);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_src_overflow();
        test_surplus();
        test_zero_job();
        test_watchdog();
        test_reset_mid_job();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
